// File: rtl/if_prefetch_unit.sv
// Instruction prefetch: fetch FSM with one outstanding memory request feeding a DEPTH-entry buffer.
// Latency: one cycle from accepted response to out_valid. Back-pressure: stall holds the head, and a full buffer stops requests.
module if_prefetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int                PW         = $clog2(DEPTH);
  localparam logic [PW:0]       DEPTH_CNT  = (PW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(PC_STEP - 1);

  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   fetch_pc, fetch_pc_nxt, req_pc;
  logic [PW:0]         count;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]   buf_pc    [DEPTH];
  logic [INSTR_W-1:0]  buf_instr [DEPTH];
  logic                req_fire, push, pop;

  assign imem_req_valid = !rst && (state == FETCH) && (count < DEPTH_CNT) && !redirect;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = !rst && (count != '0) && !redirect;
  assign out_pc    = buf_pc[rd_ptr];
  assign out_instr = buf_instr[rd_ptr];
  assign pop       = out_valid && !stall;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc & ALIGN_MASK;
        end else if (req_fire) begin
          state_nxt    = WAIT;
          fetch_pc_nxt = fetch_pc + ADDR_W'(PC_STEP);
        end
      end
      WAIT: begin
        // A response racing a redirect is stale; without one, the late beat must be swallowed.
        if (redirect) begin
          fetch_pc_nxt = redirect_pc & ALIGN_MASK;
          state_nxt    = imem_rsp_valid ? FETCH : DISCARD;
        end else if (imem_rsp_valid) begin
          push      = 1'b1;
          state_nxt = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) fetch_pc_nxt = redirect_pc & ALIGN_MASK;
        if (imem_rsp_valid) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Data storage needs no reset; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (req_fire) req_pc <= fetch_pc;
    if (push) begin
      buf_pc[wr_ptr]    <= req_pc;
      buf_instr[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: transaction-level memory/scoreboard model plus directed scenarios.
module tb_if_prefetch_unit;

  localparam int            AW    = 16;
  localparam int            IW    = 16;
  localparam int            DEPTH = 4;
  localparam int            STEP  = 2;
  localparam logic [AW-1:0] RPC   = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [IW-1:0] imem_rsp_data = '0;
  logic          imem_req_valid, out_valid;
  logic [AW-1:0] imem_req_addr, out_pc;
  logic [IW-1:0] out_instr;
  logic          w_req_valid, w_out_valid;
  logic [AW-1:0] w_req_addr, w_out_pc;
  logic [IW-1:0] w_out_instr;

  always #5 clk = ~clk;

  if_prefetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr)
  );

  if_prefetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(w_out_valid), .out_pc(w_out_pc), .out_instr(w_out_instr)
  );

  int checks = 0;
  int errors = 0;

  // Model: expected instruction stream as a queue of PCs, plus the memory's single pending request.
  logic [AW-1:0] m_fetch = RPC;
  logic [AW-1:0] m_req_pc = '0;
  logic [AW-1:0] q_pc[$];
  bit            pending = 0, stale = 0;
  int            lat = 0, force_lat = -1;

  logic [AW-1:0] obs[$];
  logic [AW-1:0] w_hs[$];
  logic          s_req_vld, s_out_vld;
  logic [AW-1:0] s_req_addr, s_out_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
    return IW'(16'hA000 + a);
  endfunction

  task automatic cycle();
    bit ev, eo, hs, rsp, pop, acc;
    rsp            = !rst && pending && (lat == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_data(m_req_pc) : IW'($urandom);
    #4;
    ev = !rst && !pending && (q_pc.size() < DEPTH) && !redirect;
    eo = !rst && (q_pc.size() != 0) && !redirect;
    s_req_vld = imem_req_valid; s_req_addr = imem_req_addr;
    s_out_vld = out_valid;      s_out_pc   = out_pc;
    check("req_vld", 32'(imem_req_valid), 32'(ev));
    if (ev) check("req_addr", 32'(imem_req_addr), 32'(m_fetch));
    check("out_vld", 32'(out_valid), 32'(eo));
    if (eo) begin
      check("out_pc", 32'(out_pc), 32'(q_pc[0]));
      check("out_instr", 32'(out_instr), 32'(mem_data(q_pc[0])));
    end
    if (!rst && out_valid && !stall) obs.push_back(out_pc);
    if (!rst && w_req_valid && imem_req_ready) w_hs.push_back(w_req_addr);
    if (rst) begin
      m_fetch = RPC; q_pc.delete(); pending = 0; stale = 0;
    end else begin
      hs  = ev && imem_req_ready;
      pop = eo && !stall;
      acc = rsp && !stale && !redirect;
      if (rsp) begin pending = 0; stale = 0; end
      if (redirect) begin
        q_pc.delete();
        m_fetch = redirect_pc & ~AW'(STEP - 1);
        if (pending) stale = 1;
      end else begin
        if (pop) void'(q_pc.pop_front());
        if (acc) q_pc.push_back(m_req_pc);
      end
      if (hs) begin
        pending  = 1;
        m_req_pc = m_fetch;
        m_fetch  = m_fetch + AW'(STEP);
        lat      = (force_lat >= 0) ? force_lat : $urandom_range(0, 2);
      end else if (pending && lat > 0) begin
        lat--;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; redirect = 0; stall = 0; imem_req_ready = 0;
    cycle();
    rst = 0;
    obs.delete(); w_hs.delete();
  endtask

  task automatic run_until_req(input string tag, input logic [AW-1:0] exp);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (s_req_vld) found = 1;
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
    if (found) check(tag, 32'(s_req_addr), 32'(exp));
  endtask

  task automatic check_obs_seq(input string tag, input int n, input logic [AW-1:0] base);
    check({tag, "_n"}, 32'(obs.size() >= n), 32'd1);
    for (int k = 0; k < n && k < obs.size(); k++)
      check(tag, 32'(obs[k]), 32'(base + AW'(k * STEP)));
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Streaming, plus wrap-around on the second instance.
    imem_req_ready = 1; force_lat = 0;
    repeat (12) cycle();
    check_obs_seq("stream", 4, 16'h0000);
    check("wrap_n", 32'(w_hs.size() >= 2), 32'd1);
    if (w_hs.size() >= 2) begin
      check("wrap_a0", 32'(w_hs[0]), 32'h0000_FFFE);
      check("wrap_a1", 32'(w_hs[1]), 32'h0000_0000);
    end

    // Back-pressure: buffer fills, requests stop, head holds.
    do_reset();
    imem_req_ready = 1; force_lat = 0; stall = 1;
    repeat (20) cycle();
    check("stall_noreq", 32'(s_req_vld), 32'd0);
    check("stall_outv", 32'(s_out_vld), 32'd1);
    check("stall_head", 32'(s_out_pc), 32'd0);
    stall = 0; obs.delete();
    repeat (12) cycle();
    check_obs_seq("drain", 5, 16'h0000);

    // Redirect in WAIT with no response: late beat discarded.
    do_reset();
    imem_req_ready = 1; force_lat = 3;
    cycle();
    redirect = 1; redirect_pc = 16'h0101;
    cycle();
    redirect = 0;
    run_until_req("disc_addr", 16'h0100);
    check("disc_drop", 32'(obs.size()), 32'd0);

    // Redirect coinciding with a response, buffer non-empty.
    do_reset();
    imem_req_ready = 1; force_lat = 0; stall = 1;
    repeat (4) cycle();
    force_lat = 1;
    for (int i = 0; i < 10 && !(pending && lat == 0); i++) cycle();
    check("rr_rsp_ready", 32'(pending && lat == 0), 32'd1);
    redirect = 1; redirect_pc = 16'h0200;
    cycle();
    redirect = 0; stall = 0; obs.delete();
    for (int i = 0; i < 20 && obs.size() == 0; i++) cycle();
    check_obs_seq("rr_first", 1, 16'h0200);

    // Reset while a request is in flight.
    do_reset();
    imem_req_ready = 1; force_lat = 3;
    cycle(); cycle();
    rst = 1;
    cycle();
    check("rst_outv", 32'(s_out_vld), 32'd0);
    rst = 0;
    run_until_req("rst_addr", RPC);

    // Random traffic against the model.
    force_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect       = ($urandom_range(0, 15) == 0);
      redirect_pc    = AW'($urandom);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, PC and memory address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch buffer entries; power of 2, at least 2.
REQ-004 SHALL have parameter PC_STEP, default 2, sequential PC increment; power of 2.
REQ-005 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-007 SHALL have port stall, input, 1 bit: downstream cannot accept this cycle.
REQ-008 SHALL have port redirect, input, 1 bit: branch taken, flush and refetch.
REQ-009 SHALL have port redirect_pc, input, ADDR_W bits: branch target.
REQ-010 SHALL have port imem_req_valid, output, 1 bit: fetch request.
REQ-011 SHALL have port imem_req_addr, output, ADDR_W bits: fetch address.
REQ-012 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-013 SHALL have port imem_rsp_valid, input, 1 bit: response data valid.
REQ-014 SHALL have port imem_rsp_data, input, INSTR_W bits: fetched instruction.
REQ-015 SHALL have port out_valid, output, 1 bit: out_pc/out_instr hold a valid instruction.
REQ-016 SHALL have port out_pc, output, ADDR_W bits: PC of the head instruction.
REQ-017 SHALL have port out_instr, output, INSTR_W bits: head instruction.

Function
REQ-018 SHALL implement the fetch FSM states FETCH, WAIT and DISCARD, with at most one outstanding memory request.
REQ-019 SHALL drive imem_req_valid = (state==FETCH) & (count < DEPTH) & !redirect, where count is the number of buffered entries, and drive imem_req_addr = fetch_pc.
REQ-020 SHALL, in FETCH, on imem_req_valid & imem_req_ready, move to WAIT, latch req_pc = fetch_pc, and set fetch_pc = fetch_pc + PC_STEP, modulo 2^ADDR_W (wraps to 0).
REQ-021 SHALL, in WAIT, on imem_rsp_valid & !redirect, push {req_pc, imem_rsp_data} into the buffer and return to FETCH.
REQ-022 SHALL, while imem_req_valid & !imem_req_ready, hold imem_req_addr stable.
REQ-023 SHALL, on redirect in FETCH, set fetch_pc = redirect_pc with the low log2(PC_STEP) bits cleared and remain in FETCH.
REQ-024 SHALL, on redirect in WAIT without imem_rsp_valid, load fetch_pc as in REQ-023 and move to DISCARD.
REQ-025 SHALL, on redirect in WAIT with imem_rsp_valid, drop the response, load fetch_pc and move to FETCH.
REQ-026 SHALL, in DISCARD, drop the next imem_rsp_valid beat and move to FETCH; a redirect in DISCARD only reloads fetch_pc.
REQ-027 SHALL ignore imem_rsp_valid in FETCH.
REQ-028 SHALL, on redirect, empty the buffer (count = 0) in the same clock edge, with redirect having priority over push and pop.
REQ-029 SHALL drive out_valid = (count != 0) & !redirect, with out_pc/out_instr as the buffer head (registered storage, no response-to-output bypass).
REQ-030 SHALL pop on out_valid & !stall; a simultaneous push and pop leaves count unchanged, including at count == DEPTH.
REQ-031 SHALL give one-cycle latency from a response to out_valid: a response accepted at edge N is visible at the output after edge N.
REQ-032 SHALL, while count == DEPTH, issue no request (REQ-019), so overflow is impossible; stall indefinitely holds the head stable.
REQ-033 SHALL, on pop while empty, do nothing; the pointers use log2(DEPTH)-bit wrap-around indices and count is a log2(DEPTH)+1-bit counter.

Reset
REQ-034 SHALL, with rst high at a rising edge, set state = FETCH, fetch_pc = RESET_PC and count = 0, and drive out_valid = 0 and imem_req_valid = 0 during reset.
REQ-035 SHALL, on reset mid-WAIT, abandon the in-flight response; the bench deasserts imem_rsp_valid for that beat, and any late beat is ignored by REQ-027.
REQ-036 SHALL issue the first request in the first cycle with rst low: imem_req_addr = RESET_PC.

Verification
REQ-037 SHALL cover streaming: ready=1, response 1 cycle after each request with data 0xA000+addr -> out_pc 0,2,4,6 in order with matching out_instr.
REQ-038 SHALL cover back-pressure: stall=1 for 20 cycles with default DEPTH=4 -> count saturates at 4, imem_req_valid=0, head stays pc=0; releasing stall drains pc 0,2,4,6 then resumes at 8.
REQ-039 SHALL cover redirect in WAIT: redirect_pc=0x0101 with no response pending -> DISCARD, the next response is dropped, and the next request addr = 0x0100.
REQ-040 SHALL cover redirect with simultaneous rsp_valid: the response is dropped, the buffer empties, and the next out_pc equals the redirect target.
REQ-041 SHALL cover wrap: RESET_PC=0xFFFE -> fetch addresses 0xFFFE then 0x0000.
REQ-042 SHALL cover reset mid-WAIT: rst for 1 cycle -> out_valid=0, and the next request addr = RESET_PC.
